// File: rtl/branch_predict_unit_pkg.sv
// Shared types, constants and helpers for the branch predict unit.
// Counter encoding, PC step and BHT index extraction live here.
package branch_predict_unit_pkg;

  localparam int unsigned PC_W      = 32;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned MAX_IDX_W = 10;

  localparam logic [CNT_W-1:0] SNT = 2'b00;
  localparam logic [CNT_W-1:0] WNT = 2'b01;
  localparam logic [CNT_W-1:0] WT  = 2'b10;
  localparam logic [CNT_W-1:0] ST  = 2'b11;

  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  // BHT index: pc[idx_w+1:2], returned zero-extended to MAX_IDX_W bits
  function automatic logic [MAX_IDX_W-1:0] bht_idx(input logic [PC_W-1:0] pc,
                                                   input int unsigned     idx_w);
    logic [MAX_IDX_W-1:0] mask;
    mask = MAX_IDX_W'((32'd1 << idx_w) - 32'd1);
    return pc[MAX_IDX_W+1:2] & mask;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// ID/EX facing bundle of the branch predict unit: prediction request,
// resolution inputs, flush/redirect and statistics outputs.
interface branch_predict_unit_if;
  import branch_predict_unit_pkg::*;

  logic            id_branch_i;
  logic [PC_W-1:0] id_pc_i;
  logic            predict_o;
  logic            ex_branch_i;
  logic            ex_predict_i;
  logic            ex_taken_i;
  logic [PC_W-1:0] ex_pc_i;
  logic [PC_W-1:0] ex_pc_target_i;
  logic            flush_o;
  logic [PC_W-1:0] redirect_pc_o;
  logic [PC_W-1:0] branch_cnt_o;
  logic [PC_W-1:0] mispredict_cnt_o;

  modport master (
    output id_branch_i, id_pc_i, ex_branch_i, ex_predict_i, ex_taken_i,
           ex_pc_i, ex_pc_target_i,
    input  predict_o, flush_o, redirect_pc_o, branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  id_branch_i, id_pc_i, ex_branch_i, ex_predict_i, ex_taken_i,
           ex_pc_i, ex_pc_target_i,
    output predict_o, flush_o, redirect_pc_o, branch_cnt_o, mispredict_cnt_o
  );

endinterface

// File: rtl/branch_predict_unit_sat_counter2.sv
// One 2-bit saturating BHT counter; inc/dec qualified by en,
// asynchronous reset to CNT_RESET.
module sat_counter2
  import branch_predict_unit_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_RESET = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_RESET;
    end else if (en) begin
      if (inc && cnt_q != ST) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (dec && cnt_q != SNT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: combinational ID prediction, EX resolution with
// same-cycle flush/redirect, counter training and saturating statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned      IDX_W     = 4,
  parameter logic [CNT_W-1:0] CNT_RESET = WNT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  branch_predict_unit_if.slave  bus
);

  localparam int unsigned N = 32'd1 << IDX_W;

  logic [CNT_W-1:0] bht [N];
  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             mispredict;
  logic [PC_W-1:0]  branch_cnt_q;
  logic [PC_W-1:0]  mispredict_cnt_q;

  assign id_idx = IDX_W'(bht_idx(bus.id_pc_i, IDX_W));
  assign ex_idx = IDX_W'(bht_idx(bus.ex_pc_i, IDX_W));

  // One counter per entry; only the entry addressed by a resolving branch moves
  for (genvar i = 0; i < N; i++) begin : g_bht
    sat_counter2 #(
      .CNT_RESET(CNT_RESET)
    ) u_cnt (
      .clk(clk_i),
      .rst(rst_i),
      .en (bus.ex_branch_i && (ex_idx == IDX_W'(i))),
      .inc(bus.ex_taken_i),
      .dec(!bus.ex_taken_i),
      .cnt(bht[i])
    );
  end

  // ID reads the pre-update table value; no bypass from the EX write
  assign bus.predict_o = bus.id_branch_i & bht[id_idx][1];

  assign mispredict = bus.ex_branch_i & (bus.ex_predict_i ^ bus.ex_taken_i);

  always_comb begin
    bus.flush_o       = mispredict;
    bus.redirect_pc_o = '0;
    if (mispredict) begin
      bus.redirect_pc_o = bus.ex_taken_i ? bus.ex_pc_target_i : bus.ex_pc_i + PC_INC;
    end
  end

  // Statistics saturate at all-ones rather than wrapping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      if (bus.ex_branch_i && branch_cnt_q != '1) begin
        branch_cnt_q <= branch_cnt_q + PC_W'(1);
      end
      if (mispredict && mispredict_cnt_q != '1) begin
        mispredict_cnt_q <= mispredict_cnt_q + PC_W'(1);
      end
    end
  end

  assign bus.branch_cnt_o     = branch_cnt_q;
  assign bus.mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed and random stimulus
// scored against an integer-array predictor model.
module tb_branch_predict_unit;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned N     = 16;
  localparam longint      SAT   = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_predict_unit_if bus ();

  branch_predict_unit #(
    .IDX_W    (IDX_W),
    .CNT_RESET(2'b01)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic        predict;
    logic        flush;
    logic [31:0] redirect;
    logic [31:0] bcnt;
    logic [31:0] mcnt;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     model[N];
  longint m_b;
  longint m_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = 1;
    m_b = 0;
    m_m = 0;
  endtask

  // Drive one cycle of inputs, queue the expected outputs, advance the model
  task automatic step(input string tag, input logic idb, input logic [31:0] idpc,
                      input logic exb, input logic exp, input logic ext,
                      input logic [31:0] expc, input logic [31:0] extgt);
    exp_t e;
    int   k;
    bus.id_branch_i    = idb;
    bus.id_pc_i        = idpc;
    bus.ex_branch_i    = exb;
    bus.ex_predict_i   = exp;
    bus.ex_taken_i     = ext;
    bus.ex_pc_i        = expc;
    bus.ex_pc_target_i = extgt;
    e.tag      = tag;
    e.predict  = idb && (model[idx_of(idpc)] >= 2);
    e.flush    = exb && (exp != ext);
    e.redirect = e.flush ? (ext ? extgt : expc + 32'd4) : 32'd0;
    e.bcnt     = 32'(m_b);
    e.mcnt     = 32'(m_m);
    sb.push_back(e);
    if (exb) begin
      k = idx_of(expc);
      model[k] = ext ? ((model[k] < 3) ? model[k] + 1 : 3)
                     : ((model[k] > 0) ? model[k] - 1 : 0);
      if (m_b < SAT) m_b++;
      if (e.flush && m_m < SAT) m_m++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are valid every cycle, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".predict"},  32'(bus.predict_o),  32'(e.predict));
        check({e.tag, ".flush"},    32'(bus.flush_o),    32'(e.flush));
        check({e.tag, ".redirect"}, bus.redirect_pc_o,   e.redirect);
        check({e.tag, ".bcnt"},     bus.branch_cnt_o,    e.bcnt);
        check({e.tag, ".mcnt"},     bus.mispredict_cnt_o, e.mcnt);
      end
    end
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] pc2;
    rst = 1'b1;
    bus.id_branch_i    = 1'b0;
    bus.id_pc_i        = '0;
    bus.ex_branch_i    = 1'b0;
    bus.ex_predict_i   = 1'b0;
    bus.ex_taken_i     = 1'b0;
    bus.ex_pc_i        = '0;
    bus.ex_pc_target_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    step("rst_state", 1, 32'h40, 0, 0, 0, 32'h0, 32'h0);
    step("mp_taken",  1, 32'h40, 1, 0, 1, 32'h40, 32'h100);
    step("after_tr",  1, 32'h40, 1, 1, 1, 32'h40, 32'h100);
    step("mp_ntkn",   1, 32'h80, 1, 1, 0, 32'h80, 32'h200);
    step("stay_t",    1, 32'h80, 0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step("sat_hi", 1, 32'h44, 1, 1, 1, 32'h44, 32'h400);
    for (int i = 0; i < 5; i++) step("sat_lo", 1, 32'h44, 1, 0, 0, 32'h44, 32'h400);
    step("sat_lo_chk", 1, 32'h44, 0, 0, 0, 32'h0, 32'h0);
    step("coll_same",  1, 32'h48, 1, 0, 1, 32'h88, 32'h500);
    step("coll_next",  1, 32'h48, 0, 0, 0, 32'h0, 32'h0);
    step("bubble",     1, 32'h4C, 0, 1, 0, 32'h4C, 32'hDEAD_BEEF);
    step("no_id",      0, 32'h48, 0, 1, 1, 32'h48, 32'h0);
    step("pc_wrap",    0, 32'h0, 1, 1, 0, 32'hFFFF_FFFC, 32'h10);

    for (int i = 0; i < 400; i++) begin
      pc  = $urandom;
      pc2 = $urandom;
      step("rand", 1'($urandom_range(0, 1)), pc, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           {$urandom_range(0, 3) == 0 ? 26'($urandom) : 26'h0, pc2[5:0]}, $urandom);
    end

    // Train away from reset values, then reset asynchronously mid-cycle
    for (int i = 0; i < 4; i++) step("pre_rst", 0, 32'h0, 1, 0, 1, 32'(i * 4), 32'h0);
    bus.ex_branch_i = 1'b0;
    bus.id_branch_i = 1'b1;
    bus.id_pc_i     = 32'h0;
    #1;
    check("pre_rst.predict", 32'(bus.predict_o), 32'(model[0] >= 2));
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst.bcnt", bus.branch_cnt_o, 32'(m_b));
    check("arst.mcnt", bus.mispredict_cnt_o, 32'(m_m));
    for (int i = 0; i < N; i++) begin
      bus.id_pc_i = 32'(i * 4);
      #0.1;
      check("arst.predict", 32'(bus.predict_o), 32'(model[i] >= 2));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", 1, 32'h40, 1, 0, 1, 32'h40, 32'h100);
    step("post_rst2", 1, 32'h40, 0, 0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
